mdu_iter: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, for the next-generation MIPS datapath.
- Replaces single-cycle-only ALU arithmetic for mult/multu/div/divu, with mthi/mtlo and mfhi/mflo support.
- Sits beside the ALU. The controller stalls the PC while `busy` is high.
- Parametrised in datapath width and radix (bits retired per cycle).

---
 rtl/mdu_iter.sv | 150 +++++++++++++++
 tb/tb_mdu_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_iter                                                                   |
// | Iterative multiply/divide unit with HI/LO, BPC bits retired per RUN cycle. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] c_last = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_div, r_neg_q, r_neg_r, r_bz;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH+BPC-1:0] w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod_fix;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_rem, w_quo, w_quo_fix, w_rem_fix;

  assign w_a_neg = op[0] & a[WIDTH-1];
  assign w_b_neg = op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right BPC per step.
  assign w_mul_sum  = {{BPC{1'b0}}, r_acc[2*WIDTH-1:WIDTH]}
                    + ({{BPC{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_acc[BPC-1:0]});
  assign w_mul_next = (2*WIDTH)'({w_mul_sum, r_acc[WIDTH-1:0]} >> BPC);

  // Divide: r_acc = {partial remainder, dividend/quotient}, BPC restoring steps per cycle.
  always_comb begin
    w_rem   = r_acc[2*WIDTH-1:WIDTH];
    w_quo   = r_acc[WIDTH-1:0];
    w_shift = '0;
    for (int i = 0; i < BPC; i++) begin
      w_shift = {w_rem, w_quo[WIDTH-1]};
      w_rem   = WIDTH'((w_shift >= {1'b0, r_opnd}) ? (w_shift - {1'b0, r_opnd}) : w_shift);
      w_quo   = {w_quo[WIDTH-2:0], (w_shift >= {1'b0, r_opnd})};
    end
    w_div_next = {w_rem, w_quo};
  end

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_bz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (r_cnt == c_last) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_div   <= op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bz    <= (b == '0);
            r_opnd  <= op[1] ? w_b_mag : w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_cnt   <= '0;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        ST_RUN: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          done <= 1'b1;
          if (r_div) begin
            hi <= w_rem_fix;
            lo <= w_quo_fix;
            dz <= r_bz;
          end else begin
            hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdu_iter                                                                |
// | Scoreboard bench for mdu_iter at 32/1 and 16/4.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mdu_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s1, wh1, wl1, busy1, done1, dz1;
  logic [1:0]  op1;
  logic [31:0] a1, b1, wd1, hi1, lo1;
  logic        s2, wh2, wl2, busy2, done2, dz2;
  logic [1:0]  op2;
  logic [15:0] a2, b2, wd2, hi2, lo2;

  mdu_iter #(.WIDTH(32), .BPC(1)) u_dut32 (
    .clk(clk), .rst(rst), .start(s1), .op(op1), .a(a1), .b(b1),
    .wr_hi(wh1), .wr_lo(wl1), .wdata(wd1),
    .busy(busy1), .done(done1), .dz(dz1), .hi(hi1), .lo(lo1)
  );

  mdu_iter #(.WIDTH(16), .BPC(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(s2), .op(op2), .a(a2), .b(b2),
    .wr_hi(wh2), .wr_lo(wl2), .wdata(wd2),
    .busy(busy2), .done(done2), .dz(dz2), .hi(hi2), .lo(lo2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic mdz1, mdz2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic dz_in);
    exp_t        e;
    logic [63:0] mask, p, t;
    longint      x, y, q, r;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, a & mask[31:0]};
    y = {32'd0, b & mask[31:0]};
    if (op[0] && a[w-1]) x = x - (longint'(1) << w);
    if (op[0] && b[w-1]) y = y - (longint'(1) << w);
    e.dz = dz_in;
    if (!op[1]) begin
      p    = x * y;
      t    = p >> w;
      e.lo = p[31:0] & mask[31:0];
      e.hi = t[31:0] & mask[31:0];
    end else if (y == 0) begin
      e.lo = mask[31:0];
      e.hi = a & mask[31:0];
      e.dz = 1'b1;
    end else begin
      q    = x / y;
      r    = x % y;
      p    = q;
      t    = r;
      e.lo = p[31:0] & mask[31:0];
      e.hi = t[31:0] & mask[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drives start at the current negedge; returns at the next negedge with a/b scrambled.
  task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (d == 1) begin
      e = model(32, op, a, b, mdz1);
      mdz1 = e.dz;
      q1.push_back(e);
      s1 = 1'b1; op1 = op; a1 = a; b1 = b;
      @(negedge clk);
      s1 = 1'b0; op1 = ~op; a1 = $urandom; b1 = $urandom;
    end else begin
      e = model(16, op, a, b, mdz2);
      mdz2 = e.dz;
      q2.push_back(e);
      s2 = 1'b1; op2 = op; a2 = a[15:0]; b2 = b[15:0];
      @(negedge clk);
      s2 = 1'b0; op2 = ~op; a2 = 16'($urandom); b2 = 16'($urandom);
    end
  endtask

  task automatic wait_done(input int d, input int exp_busy);
    int nb;
    bit seen;
    seen = 1'b0;
    nb   = ((d == 1) ? busy1 : busy2) ? 1 : 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if ((d == 1) ? done1 : done2) seen = 1'b1;
      else if ((d == 1) ? busy1 : busy2) nb++;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (exp_busy > 0) check("busy_len", nb, exp_busy);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) check("d32_spurious_done", 32'(q1.size()), 32'd1);
      else begin
        e = q1.pop_front();
        check("d32_hi", hi1, e.hi);
        check("d32_lo", lo1, e.lo);
        check("d32_dz", {31'd0, dz1}, {31'd0, e.dz});
      end
    end
    if (!rst && done2) begin
      if (q2.size() == 0) check("d16_spurious_done", 32'(q2.size()), 32'd1);
      else begin
        e = q2.pop_front();
        check("d16_hi", {16'd0, hi2}, e.hi);
        check("d16_lo", {16'd0, lo2}, e.lo);
        check("d16_dz", {31'd0, dz2}, {31'd0, e.dz});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          nd;
    rst = 1'b1; mdz1 = 1'b0; mdz2 = 1'b0;
    s1 = 0; wh1 = 0; wl1 = 0; op1 = 0; a1 = 0; b1 = 0; wd1 = 0;
    s2 = 0; wh2 = 0; wl2 = 0; op2 = 0; a2 = 0; b2 = 0; wd2 = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_dz",   {31'd0, dz1},   32'd0);
    check("rst_hi",   hi1, 32'd0);
    check("rst_lo",   lo1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-scale unsigned product, latency and one-cycle done
    issue(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, 33);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done1}, 32'd0);

    issue(1, 2'b01, 32'hFFFF_FFF9, 32'd6);          wait_done(1, 33);
    issue(1, 2'b11, 32'hFFFF_FFF9, 32'd2);          wait_done(1, 0);
    issue(1, 2'b10, 32'd100, 32'd0);                wait_done(1, 33);
    issue(1, 2'b10, 32'd100, 32'd7);                wait_done(1, 0);
    issue(1, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(1, 0);

    // Start accepted in the done cycle
    issue(1, 2'b11, 32'd1000, 32'hFFFF_FFFD);
    check("b2b_busy", {31'd0, busy1}, 32'd1);
    wait_done(1, 33);

    // mthi/mtlo in IDLE, ignored while busy, dropped alongside start
    wh1 = 1; wl1 = 1; wd1 = 32'h1234;
    @(negedge clk);
    wh1 = 0; wl1 = 0;
    check("mthi", hi1, 32'h1234);
    check("mtlo", lo1, 32'h1234);
    issue(1, 2'b00, 32'd3, 32'd5);
    wh1 = 1; wl1 = 1; wd1 = 32'hDEAD;
    repeat (5) @(negedge clk);
    check("hold_hi_busy", hi1, 32'h1234);
    check("hold_lo_busy", lo1, 32'h1234);
    wh1 = 0; wl1 = 0;
    wait_done(1, 0);
    wh1 = 1; wl1 = 1; wd1 = 32'hBEEF;
    issue(1, 2'b00, 32'd2, 32'd3);
    wh1 = 0; wl1 = 0;
    check("start_wins_hi", hi1, 32'd0);
    check("start_wins_lo", lo1, 32'd15);
    wait_done(1, 0);

    // Reset mid-operation
    issue(1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_done", {31'd0, done1}, 32'd0);
    check("abort_hi",   hi1, 32'd0);
    check("abort_lo",   lo1, 32'd0);
    q1.delete();
    mdz1 = 1'b0; mdz2 = 1'b0;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    check("no_done_after_abort", nd, 0);

    // Radix-16, 16-bit instance
    issue(2, 2'b00, 32'hFFFF, 32'hFFFF);  wait_done(2, 5);
    issue(2, 2'b01, 32'hFFF9, 32'd6);     wait_done(2, 5);
    issue(2, 2'b11, 32'hFFF9, 32'd2);     wait_done(2, 0);
    issue(2, 2'b10, 32'd100, 32'd0);      wait_done(2, 0);
    issue(2, 2'b10, 32'd100, 32'd7);      wait_done(2, 0);
    issue(2, 2'b11, 32'h8000, 32'hFFFF);  wait_done(2, 0);
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      issue(2, rop, ra, rb);
      wait_done(2, 0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(q1.size() + q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
